// File: rtl/frame_buffer_reader_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_reader_if
//   Bundles the control, SRAM and pixel-stream signals of the frame buffer
//   reader.
//
//   modport master : the reader core. It drives the SRAM strobes and address
//                    and the pixel stream, and receives start/abort, read
//                    data and pix_ready.
//   modport slave  : the surroundings (controller, SRAM, downstream sink).
//
//   Signals:
//     start, abort          control pulses into the reader
//     read_enable           SRAM read strobe
//     write_enable          SRAM write strobe (always 0, the reader never writes)
//     address               SRAM word address of the first word of the access
//     read_data             one full line, word i at [i*WORD_BITS +: WORD_BITS]
//     pix_valid/pix_ready   pixel handshake
//     pix_data/pix_x/pix_y  pixel color and raster position
//     busy, frame_done      status
//
//   Pixel handshake: a pixel transfers on every rising edge where pix_valid
//   and pix_ready are both 1. Once pix_valid is raised, pix_valid, pix_data,
//   pix_x and pix_y stay unchanged until that transfer happens (or an abort
//   or reset ends the frame). pix_ready may change freely.
// ---------------------------------------------------------------------------
interface frame_buffer_reader_if #(
  parameter int ADDR_BITS = 24,
  parameter int WORDS     = 64,
  parameter int WORD_BITS = 24,
  parameter int LINES     = 64
);
  localparam int X_BITS = $clog2(WORDS);
  localparam int Y_BITS = $clog2(LINES);

  logic                       start;
  logic                       abort;
  logic                       read_enable;
  logic                       write_enable;
  logic [ADDR_BITS-1:0]       address;
  logic [WORDS*WORD_BITS-1:0] read_data;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [WORD_BITS-1:0]       pix_data;
  logic [X_BITS-1:0]          pix_x;
  logic [Y_BITS-1:0]          pix_y;
  logic                       busy;
  logic                       frame_done;

  modport master (
    input  start, abort, read_data, pix_ready,
    output read_enable, write_enable, address,
    output pix_valid, pix_data, pix_x, pix_y, busy, frame_done
  );

  modport slave (
    output start, abort, read_data, pix_ready,
    input  read_enable, write_enable, address,
    input  pix_valid, pix_data, pix_x, pix_y, busy, frame_done
  );
endinterface

// File: rtl/frame_buffer_reader.sv
// ---------------------------------------------------------------------------
// frame_buffer_reader
//   Read side of the on-chip SRAM frame buffer. After a start pulse it fetches
//   the frame one line per wide SRAM access (WORDS pixels of WORD_BITS each),
//   holds the line in a register and streams the pixels out in raster order
//   over the pix_valid/pix_ready handshake. frame_done pulses for one cycle
//   after the last pixel of the last line has been accepted.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          synchronous, active-high reset
//     bus          frame_buffer_reader_if.master (control, SRAM, pixel stream)
//     state_dbg_o  current FSM state (0 IDLE, 1 FETCH, 2 STREAM, 3 DONE)
//
//   Timing: each line costs READ_LAT fetch cycles followed by WORDS stream
//   cycles when the sink never stalls.
// ---------------------------------------------------------------------------
module frame_buffer_reader #(
  parameter int                   ADDR_BITS = 24,
  parameter int                   WORDS     = 64,
  parameter int                   WORD_BITS = 24,
  parameter int                   LINES     = 64,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
  parameter int                   READ_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  frame_buffer_reader_if.master        bus,
  output logic [1:0]                   state_dbg_o
);

  localparam int X_BITS   = $clog2(WORDS);
  localparam int Y_BITS   = $clog2(LINES);
  localparam int LAT_BITS = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [X_BITS-1:0]    X_LAST    = X_BITS'(WORDS - 1);
  localparam logic [Y_BITS-1:0]    Y_LAST    = Y_BITS'(LINES - 1);
  localparam logic [LAT_BITS-1:0]  LAT_LAST  = LAT_BITS'(READ_LAT - 1);
  localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                     state_q,    state_d;
  logic [Y_BITS-1:0]          line_q,     line_d;
  logic [X_BITS-1:0]          x_q,        x_d;
  logic [LAT_BITS-1:0]        lat_q,      lat_d;
  logic [ADDR_BITS-1:0]       addr_q,     addr_d;
  logic [WORDS*WORD_BITS-1:0] line_reg_q, line_reg_d;

  logic accept;

  // A pixel transfers on any STREAM cycle where the sink is ready.
  assign accept = (state_q == S_STREAM) && bus.pix_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    x_d        = x_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    line_reg_d = line_reg_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          line_d  = '0;
          x_d     = '0;
          lat_d   = '0;
          addr_d  = BASE_ADDR;
        end
      end

      S_FETCH: begin
        // The strobe and address have been held for READ_LAT cycles when the
        // counter reaches its last value; read_data is valid at this edge.
        if (lat_q == LAT_LAST) begin
          line_reg_d = bus.read_data;
          lat_d      = '0;
          state_d    = S_STREAM;
        end else begin
          lat_d = lat_q + LAT_BITS'(1);
        end
      end

      S_STREAM: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (line_q == Y_LAST) begin
              // Position reads (0,0) during the DONE cycle.
              line_d  = '0;
              state_d = S_DONE;
            end else begin
              // Lines are contiguous, so the next access is one line further
              // on; the adder wraps modulo 2^ADDR_BITS.
              line_d  = line_q + Y_BITS'(1);
              addr_d  = addr_q + LINE_STEP;
              lat_d   = '0;
              state_d = S_FETCH;
            end
          end else begin
            x_d = x_q + X_BITS'(1);
          end
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // abort overrides everything above, including a capture or a pixel
    // transfer on the same edge. The address keeps its last value.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      line_d     = '0;
      x_d        = '0;
      lat_d      = '0;
      addr_d     = addr_q;
      line_reg_d = line_reg_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      x_q        <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      line_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      x_q        <= x_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      line_reg_q <= line_reg_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all decoded from registers, so they are glitch-free and stable
  // for the whole cycle.
  // -------------------------------------------------------------------------
  assign bus.read_enable  = (state_q == S_FETCH);
  assign bus.write_enable = 1'b0;
  assign bus.address      = addr_q;
  assign bus.pix_valid    = (state_q == S_STREAM);
  assign bus.pix_data     = line_reg_q[x_q*WORD_BITS +: WORD_BITS];
  assign bus.pix_x        = x_q;
  assign bus.pix_y        = line_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.frame_done   = (state_q == S_DONE);
  assign state_dbg_o      = state_q;

endmodule
